id_ex_stage_reg: RTL and testbench

ID/EX pipeline register and ALU-control decoder that sits directly upstream of the 32-bit ALU in the pipelined MIPS datapath. It captures decoded operands and control from the ID stage and selects the ALU B operand (register or immediate). It generates the registered 4-bit ALU operation code and destination register, and supports stall, flush and load-use hazard detection.

---
 rtl/id_ex_stage_reg_if.sv | 59 +++++
 rtl/id_ex_stage_reg.sv | 115 +++++++++++
 tb/tb_id_ex_stage_reg.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_reg_if.sv
// rtl/id_ex_stage_reg_if.sv - ID/EX stage bundle: ID-side capture inputs, EX-side registered outputs
// The stage consumes the slave view; the ID/EX driver side uses master.
interface id_ex_stage_reg_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      stall;
  logic                      flush;
  logic                      in_valid;
  logic [DATA_WIDTH-1:0]     in_rs_data;
  logic [DATA_WIDTH-1:0]     in_rt_data;
  logic [DATA_WIDTH-1:0]     in_imm;
  logic [REG_ADDR_WIDTH-1:0] in_rs;
  logic [REG_ADDR_WIDTH-1:0] in_rt;
  logic [REG_ADDR_WIDTH-1:0] in_rd;
  logic [1:0]                in_alu_op;
  logic [5:0]                in_funct;
  logic                      in_alu_src;
  logic                      in_reg_dst;
  logic                      in_reg_write;
  logic                      in_mem_read;
  logic                      in_mem_write;
  logic                      in_mem_to_reg;
  logic                      in_branch;

  logic [3:0]                operation;
  logic [DATA_WIDTH-1:0]     data_0;
  logic [DATA_WIDTH-1:0]     data_1;
  logic [DATA_WIDTH-1:0]     store_data;
  logic [REG_ADDR_WIDTH-1:0] rs_q;
  logic [REG_ADDR_WIDTH-1:0] rt_q;
  logic [REG_ADDR_WIDTH-1:0] write_reg;
  logic                      reg_write;
  logic                      mem_read;
  logic                      mem_write;
  logic                      mem_to_reg;
  logic                      branch;
  logic                      valid;
  logic                      illegal_op;
  logic                      hazard_stall;

  modport master (
    output stall, flush, in_valid, in_rs_data, in_rt_data, in_imm,
           in_rs, in_rt, in_rd, in_alu_op, in_funct, in_alu_src, in_reg_dst,
           in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_branch,
    input  operation, data_0, data_1, store_data, rs_q, rt_q, write_reg,
           reg_write, mem_read, mem_write, mem_to_reg, branch, valid,
           illegal_op, hazard_stall
  );

  modport slave (
    input  stall, flush, in_valid, in_rs_data, in_rt_data, in_imm,
           in_rs, in_rt, in_rd, in_alu_op, in_funct, in_alu_src, in_reg_dst,
           in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_branch,
    output operation, data_0, data_1, store_data, rs_q, rt_q, write_reg,
           reg_write, mem_read, mem_write, mem_to_reg, branch, valid,
           illegal_op, hazard_stall
  );
endinterface

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with ALU-control decode and load-use detect
// Priority on each edge: reset, flush, stall (hold), then load or bubble.
module id_ex_stage_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input logic               clock,
  input logic               reset,
  id_ex_stage_reg_if.slave  bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [3:0]                dec_op;
  logic                      dec_illegal;
  logic [REG_ADDR_WIDTH-1:0] sel_write_reg;

  logic [3:0]                op_q;
  logic [DATA_WIDTH-1:0]     data_0_q;
  logic [DATA_WIDTH-1:0]     data_1_q;
  logic [DATA_WIDTH-1:0]     store_data_q;
  logic [REG_ADDR_WIDTH-1:0] rs_r;
  logic [REG_ADDR_WIDTH-1:0] rt_r;
  logic [REG_ADDR_WIDTH-1:0] write_reg_q;
  logic                      reg_write_q;
  logic                      mem_read_q;
  logic                      mem_write_q;
  logic                      mem_to_reg_q;
  logic                      branch_q;
  logic                      valid_q;
  logic                      illegal_q;

  always_comb begin
    dec_op      = OP_AND;
    dec_illegal = 1'b0;
    case (bus.in_alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        case (bus.in_funct)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b101010: dec_op = OP_SLT;
          6'b100111: dec_op = OP_NOR;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign sel_write_reg = bus.in_reg_dst ? bus.in_rd : bus.in_rt;

  always_ff @(posedge clock) begin
    if (reset || bus.flush || (!bus.stall && !bus.in_valid)) begin
      op_q         <= '0;
      data_0_q     <= '0;
      data_1_q     <= '0;
      store_data_q <= '0;
      rs_r         <= '0;
      rt_r         <= '0;
      write_reg_q  <= '0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      branch_q     <= 1'b0;
      valid_q      <= 1'b0;
      illegal_q    <= 1'b0;
    end else if (!bus.stall) begin
      op_q         <= dec_op;
      data_0_q     <= bus.in_rs_data;
      data_1_q     <= bus.in_alu_src ? bus.in_imm : bus.in_rt_data;
      store_data_q <= bus.in_rt_data;
      rs_r         <= bus.in_rs;
      rt_r         <= bus.in_rt;
      write_reg_q  <= sel_write_reg;
      // Writes to $0 are dropped here so downstream forwarding never sees them.
      reg_write_q  <= bus.in_reg_write && (sel_write_reg != '0) && !dec_illegal;
      mem_read_q   <= bus.in_mem_read && !dec_illegal;
      mem_write_q  <= bus.in_mem_write && !dec_illegal;
      mem_to_reg_q <= bus.in_mem_to_reg;
      branch_q     <= bus.in_branch;
      valid_q      <= 1'b1;
      illegal_q    <= dec_illegal;
    end
  end

  assign bus.operation  = op_q;
  assign bus.data_0     = data_0_q;
  assign bus.data_1     = data_1_q;
  assign bus.store_data = store_data_q;
  assign bus.rs_q       = rs_r;
  assign bus.rt_q       = rt_r;
  assign bus.write_reg  = write_reg_q;
  assign bus.reg_write  = reg_write_q;
  assign bus.mem_read   = mem_read_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_to_reg = mem_to_reg_q;
  assign bus.branch     = branch_q;
  assign bus.valid      = valid_q;
  assign bus.illegal_op = illegal_q;

  // Ungated by stall/flush: ID decides how to react to the request.
  assign bus.hazard_stall = valid_q && mem_read_q && (rt_r != '0) && bus.in_valid &&
                            ((rt_r == bus.in_rs) || (rt_r == bus.in_rt));

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - randomized bench for id_ex_stage_reg against a behavioural model
// Directed scenarios first, then a random run with reset/flush/stall mixed in.
module tb_id_ex_stage_reg;

  logic clock = 1'b0;
  logic reset;
  int   tests = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  id_ex_stage_reg_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) bus ();

  id_ex_stage_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int unsigned op, d0, d1, sd, rs, rt, wr;
    int unsigned rw, mr, mw, m2r, br, vld, ill;
  } ex_state_t;

  ex_state_t   exp_s;
  int unsigned funct_op[int unsigned];
  int unsigned legal_funct[6] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h27};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    tests++;
    if (obs !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, req, $time);
    end
  endtask

  function automatic ex_state_t empty_state();
    ex_state_t s;
    s = '{default: 0};
    return s;
  endfunction

  function automatic int unsigned model_hazard();
    if (exp_s.vld == 1 && exp_s.mr == 1 && exp_s.rt != 0 && bus.in_valid &&
        (exp_s.rt == int'(bus.in_rs) || exp_s.rt == int'(bus.in_rt)))
      return 1;
    return 0;
  endfunction

  task automatic model_update();
    ex_state_t n;
    int unsigned wr;
    bit ill;
    if (reset || bus.flush) begin
      exp_s = empty_state();
    end else if (bus.stall) begin
      // hold
    end else if (!bus.in_valid) begin
      exp_s = empty_state();
    end else begin
      n = empty_state();
      ill = 0;
      if (bus.in_alu_op == 2'd0) n.op = 2;
      else if (bus.in_alu_op == 2'd1) n.op = 6;
      else if (bus.in_alu_op == 2'd2 && funct_op.exists(int'(bus.in_funct))) n.op = funct_op[int'(bus.in_funct)];
      else ill = 1;
      wr    = bus.in_reg_dst ? bus.in_rd : bus.in_rt;
      n.d0  = bus.in_rs_data;
      n.d1  = bus.in_alu_src ? bus.in_imm : bus.in_rt_data;
      n.sd  = bus.in_rt_data;
      n.rs  = bus.in_rs;
      n.rt  = bus.in_rt;
      n.wr  = wr;
      n.rw  = (bus.in_reg_write && wr != 0 && !ill) ? 1 : 0;
      n.mr  = (bus.in_mem_read && !ill) ? 1 : 0;
      n.mw  = (bus.in_mem_write && !ill) ? 1 : 0;
      n.m2r = bus.in_mem_to_reg;
      n.br  = bus.in_branch;
      n.vld = 1;
      n.ill = ill;
      exp_s = n;
    end
  endtask

  task automatic step();
    #1;
    check("hazard_stall", {31'd0, bus.hazard_stall}, exp_s.vld == 0 ? 32'd0 : model_hazard());
    model_update();
    @(posedge clock);
    #1;
    check("operation",  {28'd0, bus.operation}, exp_s.op);
    check("data_0",     bus.data_0,             exp_s.d0);
    check("data_1",     bus.data_1,             exp_s.d1);
    check("store_data", bus.store_data,         exp_s.sd);
    check("rs_q",       {27'd0, bus.rs_q},      exp_s.rs);
    check("rt_q",       {27'd0, bus.rt_q},      exp_s.rt);
    check("write_reg",  {27'd0, bus.write_reg}, exp_s.wr);
    check("reg_write",  {31'd0, bus.reg_write}, exp_s.rw);
    check("mem_read",   {31'd0, bus.mem_read},  exp_s.mr);
    check("mem_write",  {31'd0, bus.mem_write}, exp_s.mw);
    check("mem_to_reg", {31'd0, bus.mem_to_reg}, exp_s.m2r);
    check("branch",     {31'd0, bus.branch},    exp_s.br);
    check("valid",      {31'd0, bus.valid},     exp_s.vld);
    check("illegal_op", {31'd0, bus.illegal_op}, exp_s.ill);
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.flush = 0; bus.in_valid = 0;
    bus.in_rs_data = 0; bus.in_rt_data = 0; bus.in_imm = 0;
    bus.in_rs = 0; bus.in_rt = 0; bus.in_rd = 0;
    bus.in_alu_op = 0; bus.in_funct = 0;
    bus.in_alu_src = 0; bus.in_reg_dst = 0; bus.in_reg_write = 0;
    bus.in_mem_read = 0; bus.in_mem_write = 0; bus.in_mem_to_reg = 0; bus.in_branch = 0;
  endtask

  task automatic set_add(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    idle_inputs();
    bus.in_valid = 1; bus.in_alu_op = 2'b10; bus.in_funct = 6'b100000;
    bus.in_rs_data = a; bus.in_rt_data = b; bus.in_rs = 5'd1; bus.in_rt = 5'd2;
    bus.in_rd = rd; bus.in_reg_dst = 1; bus.in_reg_write = 1;
  endtask

  task automatic random_inputs();
    bus.stall = ($urandom_range(0, 5) == 0);
    bus.flush = ($urandom_range(0, 9) == 0);
    bus.in_valid = ($urandom_range(0, 3) != 0);
    bus.in_rs_data = $urandom; bus.in_rt_data = $urandom; bus.in_imm = $urandom;
    bus.in_rs = 5'($urandom_range(0, 3));
    bus.in_rt = 5'($urandom_range(0, 3));
    bus.in_rd = 5'($urandom_range(0, 31));
    bus.in_alu_op = 2'($urandom_range(0, 3));
    bus.in_funct = ($urandom_range(0, 3) != 0) ? 6'(legal_funct[$urandom_range(0, 5)]) : 6'($urandom);
    bus.in_alu_src = 1'($urandom); bus.in_reg_dst = 1'($urandom);
    bus.in_reg_write = 1'($urandom); bus.in_mem_read = 1'($urandom);
    bus.in_mem_write = 1'($urandom); bus.in_mem_to_reg = 1'($urandom);
    bus.in_branch = 1'($urandom);
  endtask

  initial begin
    funct_op[32'h20] = 2;  funct_op[32'h22] = 6;  funct_op[32'h24] = 0;
    funct_op[32'h25] = 1;  funct_op[32'h2A] = 7;  funct_op[32'h27] = 12;
    exp_s = empty_state();
    idle_inputs();

    reset = 1;
    step(); step();
    reset = 0;
    step();
    check("reset_valid", {31'd0, bus.valid}, 32'd0);

    set_add(32'd5, 32'd7, 5'd3);
    step();
    check("add_operation", {28'd0, bus.operation}, 32'h2);
    check("add_write_reg", {27'd0, bus.write_reg}, 32'd3);

    idle_inputs();
    bus.in_valid = 1; bus.in_alu_src = 1; bus.in_imm = 32'hFFFF_FFFC;
    bus.in_rt = 5'd8; bus.in_rs = 5'd4; bus.in_mem_read = 1; bus.in_reg_write = 1;
    bus.in_mem_to_reg = 1;
    step();
    check("lw_data_1", bus.data_1, 32'hFFFF_FFFC);
    check("lw_write_reg", {27'd0, bus.write_reg}, 32'd8);
    idle_inputs();
    bus.in_valid = 1; bus.in_rs = 5'd8; bus.in_rt = 5'd1;
    #1 check("lw_use_hazard", {31'd0, bus.hazard_stall}, 32'd1);
    bus.in_rs = 5'd0; bus.in_rt = 5'd9;
    #1 check("lw_no_hazard", {31'd0, bus.hazard_stall}, 32'd0);
    step();

    set_add(32'h1111, 32'h2222, 5'd6);
    step();
    for (int i = 0; i < 3; i++) begin
      set_add($urandom, $urandom, 5'd7);
      bus.stall = 1;
      step();
      check("stall_hold_data_0", bus.data_0, 32'h1111);
    end
    bus.stall = 0;
    set_add(32'hABCD, 32'h1, 5'd9);
    step();
    check("post_stall_data_0", bus.data_0, 32'hABCD);

    bus.in_mem_read = 1; bus.stall = 1; bus.flush = 1;
    step();
    check("stall_flush_valid", {31'd0, bus.valid}, 32'd0);
    check("stall_flush_op", {28'd0, bus.operation}, 32'd0);

    set_add(32'd1, 32'd2, 5'd4);
    bus.in_funct = 6'b000000;
    step();
    check("illegal_flag", {31'd0, bus.illegal_op}, 32'd1);
    check("illegal_reg_write", {31'd0, bus.reg_write}, 32'd0);
    check("illegal_valid", {31'd0, bus.valid}, 32'd1);

    set_add(32'd1, 32'd2, 5'd0);
    step();
    check("zero_reg_write", {31'd0, bus.reg_write}, 32'd0);

    set_add(32'd3, 32'd4, 5'd5);
    step();
    bus.stall = 1; reset = 1;
    step();
    reset = 0; bus.stall = 0;
    check("reset_mid_stall_valid", {31'd0, bus.valid}, 32'd0);

    for (int i = 0; i < 600; i++) begin
      random_inputs();
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 0;

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
